// File: rtl/nios2_param_update_ctrl.sv
// Debounced parameter-select controller with an Avalon-MM slave for status, edge capture and settle time.
// Changes on in_port commit to param_out only after staying stable for SETTLE cycles.
module nios2_param_update_ctrl #(
    parameter logic [15:0] DEBOUNCE_DEFAULT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_port,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [7:0]  param_out
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [DW-1:0]   sync_meta, sync_in;
    logic [DW-1:0]   candidate, candidate_n;
    logic [DW-1:0]   committed, committed_n;
    logic [DW-1:0]   edgecap, edgecap_n;
    logic [DW-1:0]   commit_set;
    logic [DW-1:0]   w1c_mask;
    logic            irqen, irqen_n;
    logic [CW-1:0]   settle_val, settle_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   cnt_last;
    logic [31:0]     readdata_n;
    logic            wr_en;
    logic            settle_wr;
    logic            unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign settle_wr    = wr_en && (address == 2'd3);
    assign unused_wdata = ^writedata[31:16];
    // A settle time of 0 behaves like 1, so the terminal count is never negative.
    assign cnt_last     = (settle_val == '0) ? '0 : settle_val - CW'(1);

    assign param_out = committed;
    assign irq       = irqen & (|edgecap);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sync_meta  <= '0;
            sync_in    <= '0;
            candidate  <= '0;
            committed  <= '0;
            edgecap    <= '0;
            irqen      <= 1'b0;
            settle_val <= DEBOUNCE_DEFAULT;
            cnt        <= '0;
            readdata   <= '0;
        end else begin
            state      <= state_n;
            sync_meta  <= in_port;
            sync_in    <= sync_meta;
            candidate  <= candidate_n;
            committed  <= committed_n;
            edgecap    <= edgecap_n;
            irqen      <= irqen_n;
            settle_val <= settle_n;
            cnt        <= cnt_n;
            readdata   <= readdata_n;
        end
    end

    // Debounce FSM next state
    always_comb begin
        state_n     = state;
        candidate_n = candidate;
        committed_n = committed;
        cnt_n       = cnt;
        commit_set  = '0;
        case (state)
            S_IDLE: begin
                if (sync_in != committed) begin
                    state_n     = S_SETTLE;
                    candidate_n = sync_in;
                    cnt_n       = '0;
                end
            end
            S_SETTLE: begin
                if (sync_in == committed) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (sync_in != candidate) begin
                    candidate_n = sync_in;
                    cnt_n       = '0;
                end else if (settle_wr) begin
                    cnt_n = '0;
                end else if (cnt == cnt_last) begin
                    state_n = S_COMMIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_COMMIT: begin
                committed_n = candidate;
                commit_set  = committed ^ candidate;
                cnt_n       = '0;
                state_n     = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Register writes; a commit setting an edgecap bit beats a same-cycle clear
    always_comb begin
        irqen_n  = irqen;
        settle_n = settle_val;
        w1c_mask = '0;
        if (wr_en) begin
            case (address)
                2'd1:    irqen_n  = writedata[0];
                2'd2:    w1c_mask = writedata[DW-1:0];
                2'd3:    settle_n = writedata[CW-1:0];
                default: ;
            endcase
        end
        edgecap_n = (edgecap & ~w1c_mask) | commit_set;
    end

    always_comb begin
        readdata_n = '0;
        case (address)
            2'd0: readdata_n = {24'd0, committed};
            2'd1: readdata_n = {31'd0, irqen};
            2'd2: readdata_n = {24'd0, edgecap};
            2'd3: readdata_n = {16'd0, settle_val};
            default: readdata_n = '0;
        endcase
    end

endmodule

// File: tb/tb_nios2_param_update_ctrl.sv
// Directed bench for nios2_param_update_ctrl: register table plus debounce/edge-capture/reset sequences.
module tb_nios2_param_update_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  param_out;

    int total = 0;
    int bad   = 0;

    nios2_param_update_ctrl #(.DEBOUNCE_DEFAULT(16'd1000)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .param_out  (param_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } reg_vec_t;

    reg_vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic check_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        tick();
        check(name, readdata, exp);
    endtask

    initial begin
        vecs[0] = '{1'b0, 2'd0, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h0,        32'h0};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h0000_03E8};
        vecs[4] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h1};
        vecs[5] = '{1'b1, 2'd3, 32'hABCD_1234, 32'h0000_1234};
        vecs[6] = '{1'b1, 2'd0, 32'h0000_00FF, 32'h0};
        vecs[7] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
        vecs[8] = '{1'b1, 2'd1, 32'hFFFF_FFFE, 32'h0};
        vecs[9] = '{1'b1, 2'd3, 32'hFFFF_0004, 32'h0000_0004};

        reset = 1'b1; in_port = '0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) tick();
        check("rst_param", 32'(param_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) do_write(vecs[i].addr, vecs[i].wdata);
            check_read($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp_rd);
        end

        // Short glitch with SETTLE=4 is cancelled
        in_port = 8'h01;
        repeat (2) tick();
        in_port = 8'h00;
        repeat (12) tick();
        check("glitch_param", 32'(param_out), 32'h0);
        check_read("glitch_edgecap", 2'd2, 32'h0);

        // Full debounce latency: 2 sync + 1 idle exit + 4 stable + 1 commit
        in_port = 8'h5A;
        repeat (7) tick();
        check("lat_before", 32'(param_out), 32'h0);
        tick();
        check("lat_commit", 32'(param_out), 32'h5A);
        check_read("lat_edgecap", 2'd2, 32'h5A);
        check_read("lat_data", 2'd0, 32'h5A);
        check("lat_irq_off", 32'(irq), 32'h0);

        // Edge capture and interrupt
        in_port = 8'h0F;
        repeat (10) tick();
        check("ec_param0f", 32'(param_out), 32'h0F);
        do_write(2'd2, 32'hFF);
        do_write(2'd1, 32'h1);
        check("ec_irq_clear", 32'(irq), 32'h0);
        in_port = 8'h3C;
        repeat (10) tick();
        check("ec_param3c", 32'(param_out), 32'h3C);
        check_read("ec_cap33", 2'd2, 32'h33);
        check("ec_irq_set", 32'(irq), 32'h1);
        do_write(2'd2, 32'h03);
        check_read("ec_cap30", 2'd2, 32'h30);
        check("ec_irq_still", 32'(irq), 32'h1);
        do_write(2'd2, 32'h30);
        check("ec_irq_done", 32'(irq), 32'h0);
        check_read("ec_cap0", 2'd2, 32'h0);

        // W1C on the commit cycle loses to the set
        do_write(2'd1, 32'h0);
        in_port = 8'h00;
        repeat (10) tick();
        check("w1c_param00", 32'(param_out), 32'h0);
        do_write(2'd2, 32'hFF);
        in_port = 8'h80;
        repeat (7) tick();
        check("w1c_before", 32'(param_out), 32'h0);
        do_write(2'd2, 32'hFF);
        check("w1c_param80", 32'(param_out), 32'h80);
        check_read("w1c_cap80", 2'd2, 32'h80);

        // SETTLE=0 acts as one stable cycle
        do_write(2'd3, 32'h0);
        check_read("s0_readback", 2'd3, 32'h0);
        in_port = 8'h11;
        repeat (4) tick();
        check("s0_before", 32'(param_out), 32'h80);
        tick();
        check("s0_commit", 32'(param_out), 32'h11);
        check_read("s0_data", 2'd0, 32'h11);

        // Reset during SETTLE abandons the change; full default debounce follows
        do_write(2'd3, 32'h4);
        in_port = 8'h00;
        repeat (10) tick();
        check("rs_param00", 32'(param_out), 32'h0);
        in_port = 8'hAA;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("rs_param_rst", 32'(param_out), 32'h0);
        check("rs_irq_rst", 32'(irq), 32'h0);
        reset = 1'b0;
        address = 2'd3;
        tick();
        check("rs_settle_dflt", readdata, 32'h0000_03E8);
        address = 2'd2;
        tick();
        check("rs_edgecap", readdata, 32'h0);
        repeat (1001) tick();
        check("rs_before", 32'(param_out), 32'h0);
        tick();
        check("rs_commit", 32'(param_out), 32'hAA);
        check_read("rs_cap", 2'd2, 32'hAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios2_param_update_ctrl.md
NIOS2_PARAM_UPDATE_CTRL -- requirements
Module: nios2_param_update_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_DEFAULT, default 16'd1000, reset value of the SETTLE register in cycles.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port in_port, input, 8 bits: asynchronous external parameter-select lines.
REQ-005 SHALL have port address, input, 2 bits: Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-008 SHALL have port writedata, input, 32 bits: write data.
REQ-009 SHALL have port readdata, output, 32 bits: registered read data.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt to CPU.
REQ-011 SHALL have port param_out, output, 8 bits: committed (debounced) parameter value for the datapath.

Function
REQ-012 SHALL pass in_port through a 2-flop synchronizer (sync_in); input-to-FSM latency is 2 cycles.
REQ-013 SHALL implement FSM states IDLE, SETTLE, COMMIT.
REQ-014 IDLE: if sync_in != committed -> SETTLE, candidate <= sync_in, cnt <= 0; else stay.
REQ-015 SETTLE, sync_in == committed: -> IDLE, no commit (glitch cancelled).
REQ-016 SETTLE, sync_in != candidate (and != committed): candidate <= sync_in, cnt <= 0, stay.
REQ-017 SETTLE, sync_in == candidate: cnt += 1; when cnt == eff_settle-1 -> COMMIT; eff_settle = SETTLE[15:0], except 0 is treated as 1.
REQ-018 COMMIT (one cycle): committed <= candidate, edgecap <= edgecap | (committed ^ candidate), -> IDLE.
REQ-019 param_out SHALL equal committed; it updates on the clock edge ending COMMIT.
REQ-020 Register map: 0 DATA RO {24'b0, committed}; 1 IRQEN RW bit0; 2 EDGECAP [7:0], write-1-to-clear per bit; 3 SETTLE RW [15:0].
REQ-021 A write occurs when chipselect=1 and write_n=0; unused writedata bits ignored; writes to address 0 have no effect.
REQ-022 readdata SHALL be registered every cycle from address (no read strobe): value visible one cycle after address is applied; unused bits read 0.
REQ-023 irq SHALL equal IRQEN[0] & (|edgecap), combinational from registers.
REQ-024 Same-cycle EDGECAP W1C write and COMMIT setting the same bit: set wins.
REQ-025 Write to SETTLE while in SETTLE state: cnt <= 0, new value used from next cycle.
REQ-026 cnt SHALL be 16 bits and never wrap (bounded by REQ-017).

Reset
REQ-027 While reset=1 on a clock edge: sync flops, candidate, committed, edgecap, IRQEN, readdata <= 0; cnt <= 0; SETTLE <= DEBOUNCE_DEFAULT; FSM <= IDLE; hence param_out=0, irq=0.
REQ-028 Reset asserted mid-SETTLE or COMMIT SHALL abandon the pending change with no commit or edgecap update.
REQ-029 After reset release with in_port != 0, a full debounce SHALL occur before commit.

Verification
REQ-030 SETTLE=4; in_port 0x00->0x5A held -> param_out=0x5A 2+1+4+1 cycles after change (sync, IDLE exit, 4 stable, COMMIT), edgecap=0x5A.
REQ-031 SETTLE=4; in_port 0x00->0x01 for 2 cycles then back to 0x00 -> param_out stays 0x00, edgecap stays 0, FSM returns IDLE.
REQ-032 IRQEN=1, commit 0x0F->0x3C -> edgecap=0x33, irq=1; write EDGECAP 0x03 -> edgecap=0x30, irq=1; write 0x30 -> irq=0.
REQ-033 W1C write of 0xFF on the COMMIT cycle of a 0x00->0x80 change -> edgecap=0x80 afterwards.
REQ-034 SETTLE=0 -> commit after 1 stable cycle; read address 3 -> readdata=0x00000000 one cycle later; read address 0 after commit -> committed value.
REQ-035 reset pulsed during SETTLE of 0x00->0xAA -> param_out=0, SETTLE reads DEBOUNCE_DEFAULT, then 0xAA commits after a fresh full debounce.
